// File: rtl/grevshuffle_arbiter.sv
// Round-robin arbiter sharing one grevshuffle datapath between two requesters.
// One op in flight; EXEC/WAIT cover the datapath's one-cycle registered latency.
module grevshuffle_arbiter #(
  parameter int unsigned ENABLE_SHUFFLE = 1,
  parameter int unsigned TAG_W          = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req1_op,
  input  logic [31:0]      req0_din1,
  input  logic [31:0]      req1_din1,
  input  logic [31:0]      req0_din2,
  input  logic [31:0]      req1_din2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             gs_cmd_shuffle,
  output logic             gs_cmd_unshuffle,
  output logic [31:0]      gs_din1,
  output logic [31:0]      gs_din2,
  input  logic [31:0]      gs_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_r;
  logic             rr_ptr_r;
  logic             gid_r;
  logic [TAG_W-1:0] tag_r;

  logic             gnt_s;
  logic             hs_s;
  logic             illegal_s;
  logic [1:0]       sel_op_s;
  logic [31:0]      sel_din1_s;
  logic [31:0]      sel_din2_s;
  logic [TAG_W-1:0] sel_tag_s;

  // Grant selection and request-side operand mux
  always_comb begin
    gnt_s      = 1'b0;
    sel_op_s   = req0_op;
    sel_din1_s = req0_din1;
    sel_din2_s = req0_din2;
    sel_tag_s  = req0_tag;
    if (req0_valid && req1_valid) begin
      gnt_s = rr_ptr_r;
    end else if (req1_valid) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
    if (gnt_s) begin
      sel_op_s   = req1_op;
      sel_din1_s = req1_din1;
      sel_din2_s = req1_din2;
      sel_tag_s  = req1_tag;
    end else begin
      sel_op_s   = req0_op;
      sel_din1_s = req0_din1;
      sel_din2_s = req0_din2;
      sel_tag_s  = req0_tag;
    end
    hs_s      = (state_r == IDLE) && (req0_valid || req1_valid);
    // shuffle/unshuffle are refused outright when the datapath is built without them
    illegal_s = (sel_op_s == 2'b11) ||
                ((ENABLE_SHUFFLE == 32'd0) && (sel_op_s != 2'b00));
  end

  assign req0_ready = hs_s && !gnt_s;
  assign req1_ready = hs_s && gnt_s;

  // Control FSM with registered datapath drive and response channel
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r          <= IDLE;
      rr_ptr_r         <= 1'b0;
      gid_r            <= 1'b0;
      tag_r            <= {TAG_W{1'b0}};
      rsp_valid        <= 2'b00;
      rsp_data         <= 32'd0;
      rsp_tag          <= {TAG_W{1'b0}};
      rsp_err          <= 1'b0;
      gs_cmd_shuffle   <= 1'b0;
      gs_cmd_unshuffle <= 1'b0;
      gs_din1          <= 32'd0;
      gs_din2          <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            gid_r    <= gnt_s;
            rr_ptr_r <= ~gnt_s;
            tag_r    <= sel_tag_s;
            if (illegal_s) begin
              rsp_valid <= gnt_s ? 2'b10 : 2'b01;
              rsp_data  <= 32'd0;
              rsp_tag   <= sel_tag_s;
              rsp_err   <= 1'b1;
              state_r   <= RESP;
            end else begin
              gs_din1          <= sel_din1_s;
              gs_din2          <= sel_din2_s;
              gs_cmd_shuffle   <= (sel_op_s == 2'b01);
              gs_cmd_unshuffle <= (sel_op_s == 2'b10);
              state_r          <= EXEC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          state_r <= WAIT;
        end
        WAIT: begin
          // gs_dout now reflects the operands presented during EXEC
          rsp_data         <= gs_dout;
          rsp_err          <= 1'b0;
          rsp_tag          <= tag_r;
          rsp_valid        <= gid_r ? 2'b10 : 2'b01;
          gs_din1          <= 32'd0;
          gs_din2          <= 32'd0;
          gs_cmd_shuffle   <= 1'b0;
          gs_cmd_unshuffle <= 1'b0;
          state_r          <= RESP;
        end
        RESP: begin
          if (rsp_ready[gid_r]) begin
            rsp_valid <= 2'b00;
            state_r   <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/grevshuffle_arbiter.md
Name: grevshuffle_arbiter

Overview:
- Shares one grevshuffle datapath instance between two requesters (e.g. the decode-stage ALU port and a microcoded sequencer).
- Does round-robin arbitration with valid/ready request handshakes.
- Drives the unit's command and operand inputs from registers, waits out its one-cycle registered latency, and captures the result.
- Returns the result on the granted requester's response channel, with one operation in flight at a time.

Parameters:
- ENABLE_SHUFFLE, 1: when 0, shuffle and unshuffle ops are rejected with an error response and never reach the datapath.
- TAG_W, 4: width of the per-request tag echoed back with the response.

Ports:
- clk  in  1  clock; all flops rising-edge.
- resetn  in  1  asynchronous active-low reset.
- req0_valid, req1_valid  in  1  request valid per requester.
- req0_ready, req1_ready  out  1  request accepted this cycle when valid&ready.
- req0_op, req1_op  in  2  operation: 00=grev, 01=shuffle, 10=unshuffle, 11=illegal.
- req0_din1, req1_din1  in  32  data operand.
- req0_din2, req1_din2  in  32  control operand (grev amount, or shuffle control word).
- req0_tag, req1_tag  in  TAG_W  requester tag.
- rsp_valid  out  2  one-hot response valid; bit i selects requester i.
- rsp_ready  in  2  response accept per requester.
- rsp_data  out  32  result.
- rsp_tag  out  TAG_W  tag of the completed request.
- rsp_err  out  1  1 = op not executed; rsp_data = 0.
- gs_cmd_shuffle  out  1  to datapath.
- gs_cmd_unshuffle  out  1  to datapath.
- gs_din1, gs_din2  out  32  to datapath.
- gs_dout  in  32  datapath result, valid one clock after its inputs are presented.

Behaviour:
- Reset values: all outputs 0; state=IDLE; rr_ptr=0.
- Reset is asynchronous and takes effect mid-operation. An in-flight op is dropped with no response. gs_cmd_* and rsp_valid are forced to 0 immediately.
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE, grant:
  - Only one valid: grant it.
  - Both valid: grant requester rr_ptr.
  - req_ready is high only for the granted requester, and only in IDLE. It is combinational from the valid inputs.
- IDLE, on handshake:
  - Latch op, din1, din2, tag and grant id.
  - Set rr_ptr = ~grant id. rr_ptr only changes on a grant.
  - Legal op: go to EXEC. op=11, or a shuffle/unshuffle op with ENABLE_SHUFFLE=0: go straight to RESP with rsp_err=1 and rsp_data=0.
- EXEC, 1 cycle:
  - gs_din1 and gs_din2 are registered outputs. They carry the latched operands throughout EXEC and WAIT, and are 0 otherwise.
  - gs_cmd_shuffle = (op==01); gs_cmd_unshuffle = (op==10). Both are asserted only in EXEC and WAIT.
  - Next state: WAIT.
- WAIT, 1 cycle: gs_dout is valid and is captured into rsp_data; rsp_err=0. Next state: RESP.
- RESP:
  - rsp_valid[id]=1. rsp_data, rsp_tag and rsp_err are held stable until rsp_ready[id].
  - rsp_ready on the non-granted bit is ignored.
  - On handshake, clear rsp_valid and go to IDLE. A new request is not accepted in the same cycle as the response handshake.
- Latency: request handshake in cycle t gives rsp_valid in cycle t+3. An illegal op gives rsp_valid in cycle t+1.
- Minimum throughput is one op per 4 cycles; an illegal op takes 2 cycles.
- Requests arriving while not in IDLE see ready=0 and must hold valid, per the handshake rules.
- Fairness: with both requesters continuously valid, grants strictly alternate. There is no starvation.

Test Plan:
- Reset, then req0 only: op=00, din1=0x00000001, din2=31, tag=3 → rsp_valid=01 at t+3, rsp_data=0x80000000, rsp_tag=3, rsp_err=0.
- req1 shuffle: din1=0x0000FFFF, din2=0xFFFF1000 (stage 1, full mask) → rsp_valid=10; rsp_data equals a grevshuffle golden model run on the same operands.
- Both valid continuously for 6 ops → grants 0,1,0,1,0,1 and rr_ptr toggles. Hold rsp_ready low for 5 cycles on op 2 → rsp_data and rsp_tag stable, no new req_ready during the stall.
- req0_op=11 with tag=5 → rsp_valid=01 at t+1, rsp_err=1, rsp_data=0, gs_cmd_* never asserted. With ENABLE_SHUFFLE=0, op=01 gives the same error response.
- Assert resetn low during WAIT → all outputs 0 within the same cycle, with no clock edge needed. After release, a new req1 grant completes normally with rr_ptr restarted at 0.
- Grev sweep: din1=0x12345678, din2=0..31, compared against the golden model → every result matches and the latency is always 3.
